// File: rtl/sv_mod_pkg.sv
// Shared types and helpers for the modular-reduction block.
package sv_mod_pkg;

  // Control states of the reduction engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of clock cycles an operation spends in CALC.
  function automatic int unsigned rounds(input int unsigned w, input int unsigned rpt);
    return w / rpt;
  endfunction

endpackage

// File: rtl/sv_mod_step.sv
// Combinational slice of ROUND_PER_TACT restoring-division rounds.
// Optional quotient path enabled by SV_MOD_RED_QUOT_EN.
module sv_mod_step
  import sv_mod_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ROUND_PER_TACT = 4
) (
  input  logic [DATA_WIDTH-1:0]   r_in,
  input  logic [2*DATA_WIDTH-1:0] d_in,
`ifdef SV_MOD_RED_QUOT_EN
  input  logic [DATA_WIDTH-1:0]   quot_in,
  output logic [DATA_WIDTH-1:0]   quot_out,
`endif
  output logic [DATA_WIDTH-1:0]   r_out,
  output logic [2*DATA_WIDTH-1:0] d_out
);

  logic [DATA_WIDTH-1:0]   r_t;
  logic [2*DATA_WIDTH-1:0] d_t;
  logic                    ge;
`ifdef SV_MOD_RED_QUOT_EN
  logic [DATA_WIDTH-1:0]   q_t;
`endif

  // Unrolled rounds: shift divisor right, subtract when the remainder covers it.
  always_comb begin
    r_t = r_in;
    d_t = d_in;
    ge  = 1'b0;
`ifdef SV_MOD_RED_QUOT_EN
    q_t = quot_in;
`endif
    for (int unsigned k = 0; k < ROUND_PER_TACT; k++) begin
      d_t = d_t >> 1;
      ge  = ({{DATA_WIDTH{1'b0}}, r_t} >= d_t);
      if (ge) begin
        // r >= d guarantees d fits in the low half, so the narrow subtract is exact
        r_t = r_t - d_t[DATA_WIDTH-1:0];
      end
`ifdef SV_MOD_RED_QUOT_EN
      // Shifting in from the LSB lands round k's bit at position DATA_WIDTH-1-k
      q_t = {q_t[DATA_WIDTH-2:0], ge};
`endif
    end
  end

  assign r_out = r_t;
  assign d_out = d_t;
`ifdef SV_MOD_RED_QUOT_EN
  assign quot_out = q_t;
`endif

endmodule

// File: rtl/sv_mod_red.sv
// Multi-cycle unsigned modular reduction p = a mod q (restoring division).
// Define SV_MOD_RED_QUOT_EN to add the quotient output quot_o.
module sv_mod_red
  import sv_mod_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ROUND_PER_TACT = 4
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic [DATA_WIDTH/8-1:0][7:0]   a_i,
  input  logic [DATA_WIDTH/8-1:0][7:0]   q_i,
  input  logic                           v_i,
  output logic                           ready,
  output logic [DATA_WIDTH/8-1:0][7:0]   p_o,
`ifdef SV_MOD_RED_QUOT_EN
  output logic [DATA_WIDTH/8-1:0][7:0]   quot_o,
`endif
  output logic                           v_o,
  input  logic                           rdy_i,
  output logic                           err_o
);

  localparam int unsigned R  = rounds(DATA_WIDTH, ROUND_PER_TACT);
  localparam int unsigned CW = $clog2(R) + 1;

  state_t                  state_q, state_n;
  logic [CW-1:0]           round_q, round_n;
  logic [DATA_WIDTH-1:0]   r_q, r_n;
  logic [2*DATA_WIDTH-1:0] d_q, d_n;
  logic [DATA_WIDTH-1:0]   p_n;
  logic                    v_n, err_n, ready_n;
  logic [DATA_WIDTH-1:0]   a_flat, q_flat;
  logic [DATA_WIDTH-1:0]   step_r;
  logic [2*DATA_WIDTH-1:0] step_d;
`ifdef SV_MOD_RED_QUOT_EN
  logic [DATA_WIDTH-1:0]   quot_acc_q, quot_acc_n;
  logic [DATA_WIDTH-1:0]   quot_n;
  logic [DATA_WIDTH-1:0]   step_quot;
`endif

  assign a_flat = a_i;
  assign q_flat = q_i;

  // One cycle's worth of reduction rounds.
  sv_mod_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ROUND_PER_TACT (ROUND_PER_TACT)
  ) u_step (
    .r_in     (r_q),
    .d_in     (d_q),
`ifdef SV_MOD_RED_QUOT_EN
    .quot_in  (quot_acc_q),
    .quot_out (step_quot),
`endif
    .r_out    (step_r),
    .d_out    (step_d)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    round_n = round_q;
    r_n     = r_q;
    d_n     = d_q;
    p_n     = p_o;
    v_n     = v_o;
    err_n   = err_o;
    ready_n = ready;
`ifdef SV_MOD_RED_QUOT_EN
    quot_acc_n = quot_acc_q;
    quot_n     = quot_o;
`endif
    case (state_q)
      IDLE: begin
        if (v_i) begin
          ready_n = 1'b0;
          if (q_flat == '0) begin
            // Zero modulus: report immediately with the dividend passed through
            state_n = DONE;
            p_n     = a_flat;
            err_n   = 1'b1;
            v_n     = 1'b1;
`ifdef SV_MOD_RED_QUOT_EN
            quot_n  = '1;
`endif
          end else begin
            state_n = CALC;
            r_n     = a_flat;
            d_n     = {q_flat, {DATA_WIDTH{1'b0}}};
            round_n = '0;
`ifdef SV_MOD_RED_QUOT_EN
            quot_acc_n = '0;
`endif
          end
        end
      end
      CALC: begin
        r_n     = step_r;
        d_n     = step_d;
        round_n = round_q + CW'(1);
`ifdef SV_MOD_RED_QUOT_EN
        quot_acc_n = step_quot;
`endif
        if (round_q == CW'(R - 1)) begin
          state_n = DONE;
          p_n     = step_r;
          err_n   = 1'b0;
          v_n     = 1'b1;
`ifdef SV_MOD_RED_QUOT_EN
          quot_n  = step_quot;
`endif
        end
      end
      DONE: begin
        if (rdy_i) begin
          state_n = IDLE;
          v_n     = 1'b0;
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        v_n     = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q <= IDLE;
      round_q <= '0;
      r_q     <= '0;
      d_q     <= '0;
      p_o     <= '0;
      v_o     <= 1'b0;
      err_o   <= 1'b0;
      ready   <= 1'b1;
`ifdef SV_MOD_RED_QUOT_EN
      quot_acc_q <= '0;
      quot_o     <= '0;
`endif
    end else begin
      state_q <= state_n;
      round_q <= round_n;
      r_q     <= r_n;
      d_q     <= d_n;
      p_o     <= p_n;
      v_o     <= v_n;
      err_o   <= err_n;
      ready   <= ready_n;
`ifdef SV_MOD_RED_QUOT_EN
      quot_acc_q <= quot_acc_n;
      quot_o     <= quot_n;
`endif
    end
  end

endmodule
